// File: rtl/magnitude_sqrt_pkg.sv
// Shared definitions for the magnitude square-root stage.
//   DEFAULT_WORD_SIZE : default width of the sum-of-squares operand
//   state_t           : controller states, encodings shared with the vector machine
package magnitude_sqrt_pkg;

  localparam int DEFAULT_WORD_SIZE = 24;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/magnitude_sqrt_if.sv
// Request/result bundle between the upstream Calculation stage and magnitude_sqrt.
//   start : request to capture Sum and begin a root computation
//   Sum   : unsigned sum of squares (word_size bits)
//   Root  : floor(sqrt(Sum)) (word_size/2 bits)
//   Rem   : Sum - Root*Root (word_size/2+1 bits)
//   Busy  : computation in progress
//   Done  : one-cycle pulse marking valid Root/Rem
// master = requester side, slave = magnitude_sqrt side.
interface magnitude_sqrt_if
  import magnitude_sqrt_pkg::*;
#(
  parameter int word_size = DEFAULT_WORD_SIZE
);

  logic                   start;
  logic [word_size-1:0]   Sum;
  logic [word_size/2-1:0] Root;
  logic [word_size/2:0]   Rem;
  logic                   Busy;
  logic                   Done;

  modport master (output start, Sum, input Root, Rem, Busy, Done);
  modport slave  (input start, Sum, output Root, Rem, Busy, Done);

endinterface

// File: rtl/magnitude_sqrt_sqrt_step.sv
// One digit-by-digit square-root iteration, purely combinational.
//   rem_in/rem_out   : working remainder (word_size/2+2 bits)
//   root_in/root_out : partial root (word_size/2 bits), new bit shifted in at LSB
//   bits_in          : next two operand bits, MSB pair first
module sqrt_step
  import magnitude_sqrt_pkg::*;
#(
  parameter int word_size = DEFAULT_WORD_SIZE
) (
  input  logic [word_size/2+1:0] rem_in,
  input  logic [word_size/2-1:0] root_in,
  input  logic [1:0]             bits_in,
  output logic [word_size/2+1:0] rem_out,
  output logic [word_size/2-1:0] root_out
);

  localparam int HALF = word_size / 2;

  logic [HALF+1:0] acc;
  logic [HALF+1:0] sub;
  logic [HALF+2:0] diff;
  logic            ge;
  logic            unused_rem_msbs;

  // rem_in never exceeds 2*root_in < 2^HALF, so its top two bits are always
  // zero and dropping them keeps (rem<<2 | bits) exact.
  assign acc  = {rem_in[HALF-1:0], bits_in};
  assign sub  = {root_in, 2'b01};
  assign diff = {1'b0, acc} - {1'b0, sub};
  assign ge   = ~diff[HALF+2];

  assign rem_out  = ge ? diff[HALF+1:0] : acc;
  assign root_out = {root_in[HALF-2:0], ge};

  assign unused_rem_msbs = ^rem_in[HALF+1:HALF];

endmodule

// File: rtl/magnitude_sqrt.sv
// Iterative integer square root of an accumulated sum of squares.
// One root bit per cycle, MSB first; result registered on entry to DONE
// and held until the next DONE.
//   clk : system clock (rising edge)
//   rst : asynchronous active-low reset
//   bus : magnitude_sqrt_if slave (start/Sum in, Root/Rem/Busy/Done out)
module magnitude_sqrt
  import magnitude_sqrt_pkg::*;
#(
  parameter int word_size = DEFAULT_WORD_SIZE
) (
  input logic             clk,
  input logic             rst,
  magnitude_sqrt_if.slave bus
);

  localparam int HALF = word_size / 2;
  localparam int CW   = $clog2(HALF + 1);

  state_t state, state_next;

  logic [word_size-1:0] op;
  logic [HALF+1:0]      rem_w, rem_step;
  logic [HALF-1:0]      root_w, root_step;
  logic [CW-1:0]        cnt;
  logic [HALF-1:0]      root_q;
  logic [HALF:0]        rem_q;
  logic                 busy_q, done_q;
  logic                 unused_step_msb;

  sqrt_step #(.word_size(word_size)) u_step (
    .rem_in  (rem_w),
    .root_in (root_w),
    .bits_in (op[word_size-1 -: 2]),
    .rem_out (rem_step),
    .root_out(root_step)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy/Done are registered from the next state so they track the state
  // register exactly and reset to 0 with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op     <= '0;
      rem_w  <= '0;
      root_w <= '0;
      cnt    <= '0;
      root_q <= '0;
      rem_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            op     <= bus.Sum;
            rem_w  <= '0;
            root_w <= '0;
            cnt    <= CW'(HALF);
          end
        end
        CALC: begin
          rem_w  <= rem_step;
          root_w <= root_step;
          op     <= {op[word_size-3:0], 2'b00};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            root_q <= root_step;
            rem_q  <= rem_step[HALF:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Root = root_q;
  assign bus.Rem  = rem_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

  assign unused_step_msb = rem_step[HALF+1];

endmodule

// File: tb/tb_magnitude_sqrt.sv
module tb_magnitude_sqrt;
  import magnitude_sqrt_pkg::*;

  localparam int W = DEFAULT_WORD_SIZE;
  localparam int H = W / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  magnitude_sqrt_if #(.word_size(W)) bus ();

  magnitude_sqrt #(.word_size(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] sum;
    int           root;
    int           rem;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Reference: floating-point sqrt, then nudged to the exact integer floor.
  function automatic longint ref_root(input longint s);
    longint r;
    r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // k counts rising edges after the start-sampling edge; Done is expected
  // high after edge H, i.e. the 13th edge counting the start edge as the first.
  task automatic run_calc(input logic [W-1:0] s, output int lat, output int ndone,
                          output logic [H-1:0] r, output logic [H:0] m);
    lat   = -1;
    ndone = 0;
    r     = 'x;
    m     = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Sum   = s;
    @(posedge clk);
    for (int k = 0; k <= H + 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.Sum   = W'($urandom);
      if (k == 0)     check("busy_in_calc", bus.Busy, 1);
      if (k == H + 1) check("busy_back_idle", bus.Busy, 0);
      if (bus.Done) begin
        if (ndone == 0) begin
          lat = k;
          r   = bus.Root;
          m   = bus.Rem;
        end
        ndone++;
      end
    end
  endtask

  int           lat, nd, k1, k2;
  logic [H-1:0] r, r1, r2;
  logic [H:0]   m, m1, m2;
  longint       er, em;
  logic [W-1:0] s;

  initial begin
    tbl[0] = '{24'd0,        0,    0};
    tbl[1] = '{24'd144,      12,   0};
    tbl[2] = '{24'd1000,     31,   39};
    tbl[3] = '{24'hFFFFFF,   4095, 8190};
    tbl[4] = '{24'd81,       9,    0};
    tbl[5] = '{24'd1,        1,    0};
    tbl[6] = '{24'd2,        1,    1};
    tbl[7] = '{24'd3,        1,    2};
    tbl[8] = '{24'h400000,   2048, 0};
    tbl[9] = '{24'hFFE001,   4095, 0};

    bus.start = 1'b0;
    bus.Sum   = '0;

    // Reset state
    #12;
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_root", bus.Root, 0);
    check("rst_rem",  bus.Rem,  0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      run_calc(tbl[i].sum, lat, nd, r, m);
      check("tbl_latency", lat, H);
      check("tbl_done_count", nd, 1);
      check("tbl_root", r, tbl[i].root);
      check("tbl_rem", m, tbl[i].rem);
    end

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      s = W'($urandom);
      if (i % 8 == 0) s = {W{1'b1}} - W'($urandom_range(0, 3));
      er = ref_root(longint'(s));
      em = longint'(s) - er * er;
      run_calc(s, lat, nd, r, m);
      check("rnd_latency", lat, H);
      check("rnd_root", r, er);
      check("rnd_rem", m, em);
      check("rnd_rem_bound", (m <= 2 * r), 1);
    end

    // Start held high, Sum disturbed during CALC, back-to-back restart
    @(negedge clk);
    bus.start = 1'b1;
    bus.Sum   = 24'd1000;
    @(posedge clk);
    nd = 0; k1 = -1; k2 = -1;
    r1 = 'x; r2 = 'x; m1 = 'x; m2 = 'x;
    for (int k = 0; k <= 2 * H + 4; k++) begin
      @(negedge clk);
      if (bus.Done) begin
        if (nd == 0) begin k1 = k; r1 = bus.Root; m1 = bus.Rem; end
        else         begin k2 = k; r2 = bus.Root; m2 = bus.Rem; end
        nd++;
      end
      if (k == H + 1) check("b2b_idle_gap", bus.Busy, 0);
      if (k == H + 2) check("b2b_restart", bus.Busy, 1);
      if (k == H + 6) check("b2b_root_hold", bus.Root, 31);
      if (k < H + 1) begin
        bus.start = 1'b1;
        bus.Sum   = W'($urandom);
      end else if (k == H + 1) begin
        bus.start = 1'b1;
        bus.Sum   = 24'd144;
      end else begin
        bus.start = 1'b0;
        bus.Sum   = W'($urandom);
      end
    end
    check("b2b_done_count", nd, 2);
    check("b2b_first_lat", k1, H);
    check("b2b_first_root", r1, 31);
    check("b2b_first_rem", m1, 39);
    check("b2b_second_lat", k2, 2 * H + 2);
    check("b2b_second_root", r2, 12);
    check("b2b_second_rem", m2, 0);

    // Reset asserted at iteration 6 aborts the computation
    @(negedge clk);
    bus.start = 1'b1;
    bus.Sum   = 24'hFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", bus.Busy, 0);
    check("abort_done", bus.Done, 0);
    check("abort_root", bus.Root, 0);
    check("abort_rem",  bus.Rem,  0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int k = 0; k < H + 3; k++) begin
      @(negedge clk);
      if (bus.Done) nd++;
    end
    check("abort_no_done", nd, 0);
    check("abort_idle", bus.Busy, 0);
    run_calc(24'd81, lat, nd, r, m);
    check("post_abort_latency", lat, H);
    check("post_abort_root", r, 9);
    check("post_abort_rem", m, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
